mont_exp_ctrl: RTL and testbench

- Sequencer for modular exponentiation using left-to-right square-and-multiply in the Montgomery domain.
- Owns the operand/start/done handshake of one external montgomery multiplier instance and issues every squaring and multiplication in order.
- Finishes with a multiply-by-one to leave the Montgomery domain, then returns the result.
- Sits between the RSA top-level register file and the multiplier.

---
 rtl/mont_exp_ctrl.sv | 138 +++++++++++++
 tb/tb_mont_exp_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for one external Montgomery multiplier.
// The exponent is consumed MSB-first; a final multiply-by-one returns the result to the normal domain.
module mont_exp_ctrl #(
  parameter int unsigned WIDTH   = 1024,
  parameter int unsigned E_WIDTH = 1024,
  parameter int unsigned LEN_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]   in_t,
  output logic               mont_start,
  output logic [WIDTH-1:0]   mont_a,
  output logic [WIDTH-1:0]   mont_b,
  output logic [WIDTH-1:0]   mont_m,
  input  logic [WIDTH-1:0]   mont_result,
  input  logic               mont_done,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               busy
);

  typedef enum logic [2:0] {
    StIdle,
    StIssueSq,
    StWaitSq,
    StIssueMul,
    StWaitMul,
    StIssuePost,
    StWaitPost
  } state_e;

  localparam logic [LEN_W-1:0] EMax = LEN_W'(E_WIDTH);
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);

  state_e             state_q;
  logic [WIDTH-1:0]   x_q;
  logic [E_WIDTH-1:0] e_q;
  logic [LEN_W-1:0]   idx_q;

  logic [LEN_W-1:0]   t_clamp;
  logic [LEN_W-1:0]   idx_dec;
  logic               cur_bit;

  always_comb begin
    t_clamp = (in_t > EMax) ? EMax : in_t;
    idx_dec = idx_q - LEN_W'(1);
    cur_bit = |(e_q & (E_WIDTH'(1) << idx_dec));
  end

  // mont_a doubles as the accumulator: every operation takes acc as operand A, so the
  // next operands are loaded on the same edge that enters the issue state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= '0;
      e_q        <= '0;
      idx_q      <= '0;
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
      mont_m     <= '0;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mont_start <= 1'b0;
      done       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x_q        <= in_x;
            e_q        <= in_e;
            mont_m     <= in_m;
            idx_q      <= t_clamp;
            busy       <= 1'b1;
            mont_a     <= in_r;
            mont_start <= 1'b1;
            if (t_clamp != '0) begin
              mont_b  <= in_r;
              state_q <= StIssueSq;
            end else begin
              mont_b  <= One;
              state_q <= StIssuePost;
            end
          end
        end
        StIssueSq:   state_q <= StWaitSq;
        StWaitSq: begin
          if (mont_done) begin
            idx_q      <= idx_dec;
            mont_a     <= mont_result;
            mont_start <= 1'b1;
            if (cur_bit) begin
              mont_b  <= x_q;
              state_q <= StIssueMul;
            end else if (idx_dec != '0) begin
              mont_b  <= mont_result;
              state_q <= StIssueSq;
            end else begin
              mont_b  <= One;
              state_q <= StIssuePost;
            end
          end
        end
        StIssueMul:  state_q <= StWaitMul;
        StWaitMul: begin
          if (mont_done) begin
            mont_a     <= mont_result;
            mont_start <= 1'b1;
            if (idx_q != '0) begin
              mont_b  <= mont_result;
              state_q <= StIssueSq;
            end else begin
              mont_b  <= One;
              state_q <= StIssuePost;
            end
          end
        end
        StIssuePost: state_q <= StWaitPost;
        StWaitPost: begin
          if (mont_done) begin
            result  <= mont_result;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default:     state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl: M=13, R=256, x=2 (in_x=5), behavioural 5-cycle multiplier.
`timescale 1ns/1ps
module tb_mont_exp_ctrl;
  localparam int W  = 8;
  localparam int EW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_x, in_r, in_m;
  logic [EW-1:0] in_e;
  logic [LW-1:0] in_t;
  logic          mont_start;
  logic [W-1:0]  mont_a, mont_b, mont_m, mont_result, result;
  logic          model_done, spur_done, mont_done, done, busy;

  assign mont_done = model_done | spur_done;
  always #5 clk = ~clk;

  mont_exp_ctrl #(.WIDTH(W), .E_WIDTH(EW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_t(in_t),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done),
    .result(result), .done(done), .busy(busy)
  );

  // a*b*R^-1 mod m with R = 2^W
  function automatic logic [W-1:0] mont_mul(input int a, input int b, input int m);
    int rinv;
    rinv = 0;
    if (m == 0) return '0;
    for (int r = 1; r < m; r++) if (((1 << W) * r) % m == 1) rinv = r;
    return W'((a * b * rinv) % m);
  endfunction

  int           mcnt;
  logic [W-1:0] ra, rb, rm;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= 0; model_done <= 1'b0; mont_result <= '0;
      ra <= '0; rb <= '0; rm <= '0;
    end else begin
      model_done <= 1'b0;
      if (mont_start) begin
        mcnt <= 5; ra <= mont_a; rb <= mont_b; rm <= mont_m;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          model_done  <= 1'b1;
          mont_result <= mont_mul(int'(ra), int'(rb), int'(rm));
        end
      end
    end
  end

  int exp_res_q[$];
  int exp_pul_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int pcnt = 0;
  int wd = 0;
  int rexp, pexp;
  logic after_done = 1'b0;
  logic prev_md = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every comparison of the bench happens here
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_mont_start", int'(mont_start), 0);
      chk("reset_result", int'(result), 0);
      exp_res_q.delete();
      exp_pul_q.delete();
      pcnt = 0; wd = 0; after_done = 1'b0;
    end else begin
      if (after_done) begin
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        after_done = 1'b0;
      end
      if (mont_start) begin
        pcnt++;
        chk("busy_during_op", int'(busy), 1);
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          rexp = exp_res_q.pop_front();
          pexp = exp_pul_q.pop_front();
          chk("result", int'(result), rexp);
          chk("mont_start_pulses", pcnt, pexp);
          chk("done_latency", int'(prev_md), 1);
        end
        after_done = 1'b1;
        pcnt = 0;
      end
      if (exp_res_q.size() > 0) begin
        wd++;
        if (wd > 3000) begin
          n_cmp++; n_err++;
          $display("FAIL timeout: got no done, expected one within 3000 cycles");
          void'(exp_res_q.pop_front());
          void'(exp_pul_q.pop_front());
          wd = 0;
        end
      end else begin
        wd = 0;
      end
    end
    prev_md = mont_done;
  end

  task automatic set_ops(input logic [EW-1:0] e, input logic [LW-1:0] t);
    in_m = 8'd13; in_r = 8'd9; in_x = 8'd5; in_e = e; in_t = t;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && exp_res_q.size() != 0; i++) @(negedge clk);
    if (exp_res_q.size() != 0) begin
      $display("FAIL drain: got pending=%0d, expected 0", exp_res_q.size());
      $fatal(1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [EW-1:0] e, input logic [LW-1:0] t,
                        input int res, input int pul);
    exp_res_q.push_back(res);
    exp_pul_q.push_back(pul);
    @(negedge clk);
    set_ops(e, t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    int seen;
    spur_done = 1'b0;
    set_ops(8'h05, 4'd3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op(8'h05, 4'd3, 6, 6);
    run_op(8'hFF, 4'd8, 8, 17);
    run_op(8'hA5, 4'd0, 1, 1);
    run_op(8'h00, 4'd3, 1, 4);
    run_op(8'h05, 4'd12, 6, 11);
    run_op(8'h0B, 4'd4, 7, 8);

    // stray mont_done in ISSUE_SQ, then a second start with different operands while busy
    exp_res_q.push_back(6);
    exp_pul_q.push_back(6);
    @(negedge clk);
    set_ops(8'h05, 4'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    in_x = 8'h77; in_e = 8'hFF; in_t = 4'd8; in_m = 8'd11; in_r = 8'd1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_ops(8'h05, 4'd3);
    wait_drain();

    // reset while waiting on the first multiply
    exp_res_q.push_back(6);
    exp_pul_q.push_back(6);
    @(negedge clk);
    set_ops(8'h05, 4'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 500 && seen < 2; i++) begin
      if (mont_start) seen++;
      if (seen < 2) @(negedge clk);
    end
    if (seen < 2) begin
      $display("FAIL reach_wait_mul: got %0d pulses, expected 2", seen);
      $fatal(1);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(8'h05, 4'd3, 6, 6);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
